// File: rtl/aes_pkg.sv
// Shared constants for the AES S-box sharing logic: default latency,
// result-owner encoding and a 128-bit zero constant.
package aes_pkg;
    localparam int           SBOX_LAT_DEF = 2;
    localparam logic         OWN_ST       = 1'b0;
    localparam logic         OWN_KS       = 1'b1;
    localparam logic [127:0] ZERO_128     = '0;
endpackage

// File: rtl/sbox_tag_pipe.sv
// Valid/owner shift register that follows each SUB_BYTES issue to its result,
// so the result can be steered back to whoever issued it.
module sbox_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner,
    output logic any_valid
);
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] own;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            own <= '0;
        end else begin
            vld[0] <= in_valid & ~flush;
            own[0] <= in_owner;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1] & ~flush;
                own[i] <= own[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_owner = own[DEPTH-1];
    assign any_valid = |vld;
endmodule

// File: rtl/sbox_share_arb.sv
// Arbitrates one shared SUB_BYTES datapath between the round-state path and
// the key-schedule SubWord path, and routes each result back to its owner.
module sbox_share_arb
    import aes_pkg::*;
#(
    parameter int SBOX_LAT = SBOX_LAT_DEF,
    parameter bit RR_EN    = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         st_req_valid,
    output logic         st_req_ready,
    input  logic [127:0] st_req_data,
    output logic         st_rsp_valid,
    output logic [127:0] st_rsp_data,
    input  logic         ks_req_valid,
    output logic         ks_req_ready,
    input  logic [31:0]  ks_req_word,
    output logic         ks_rsp_valid,
    output logic [31:0]  ks_rsp_word,
    output logic [127:0] sb_inp_data,
    input  logic [127:0] sb_sub_data,
    output logic         busy
);
    logic ptr;
    logic st_pri;
    logic st_gnt;
    logic ks_gnt;
    logic last_vld;
    logic last_own;
    logic any_vld;

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        st_pri = (RR_EN == 1'b0) || (ptr == OWN_ST);
        st_gnt = rst_n & ~flush & st_req_valid & (~ks_req_valid | st_pri);
        ks_gnt = rst_n & ~flush & ks_req_valid & ~(st_req_valid & st_pri);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr <= OWN_ST;
        else if (st_gnt) ptr <= OWN_KS;
        else if (ks_gnt) ptr <= OWN_ST;
    end

    sbox_tag_pipe #(.DEPTH(SBOX_LAT)) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (st_gnt | ks_gnt),
        .in_owner  (ks_gnt ? OWN_KS : OWN_ST),
        .out_valid (last_vld),
        .out_owner (last_own),
        .any_valid (any_vld)
    );

    always_comb begin
        sb_inp_data = ZERO_128;
        if (st_gnt)      sb_inp_data = st_req_data;
        else if (ks_gnt) sb_inp_data = {96'h0, ks_req_word};
    end

    assign st_req_ready = st_gnt;
    assign ks_req_ready = ks_gnt;

    assign st_rsp_valid = last_vld & (last_own == OWN_ST);
    assign ks_rsp_valid = last_vld & (last_own == OWN_KS);
    assign st_rsp_data  = st_rsp_valid ? sb_sub_data : ZERO_128;
    assign ks_rsp_word  = ks_rsp_valid ? sb_sub_data[31:0] : 32'h0;

    assign busy = rst_n & (st_req_valid | ks_req_valid | any_vld);
endmodule
